// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Purpose  : Shared constants and types for the matrix stream loader:
//            element width, largest dimension, row strides of the input and
//            kernel buses, dimension-header field positions and the loader
//            state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int PKG_ELEM_W    = 8;
    localparam int PKG_MAX_DIM   = 5;
    localparam int IN_STRIDE     = 5;   // row stride of the input-matrix bus
    localparam int KERNEL_STRIDE = 3;   // row stride of the kernel bus

    // Header byte layout: m in [6:4], n in [2:0]; bits 7 and 3 are don't-care.
    localparam int DIM_W     = 3;
    localparam int HDR_M_LSB = 4;
    localparam int HDR_N_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_index_counter.sv
`default_nettype none
// ============================================================================
// Module   : matrix_index_counter
// Purpose  : Row/column position tracker for a row-major m x n load. The
//            column wraps to 0 (and the row advances) after column n-1.
//            last flags that the current position is the final element.
// Ports    : clk, reset  - clock, synchronous active-high reset
//            clear       - return to (0,0)
//            advance     - step to the next element
//            m, n        - loaded dimensions
//            row, col    - current position
//            last        - current position is (m-1, n-1)
// Revision : 1.0 - initial release
// ============================================================================
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int DIM_BITS = DIM_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                advance,
    input  logic [DIM_BITS-1:0] m,
    input  logic [DIM_BITS-1:0] n,
    output logic [DIM_BITS-1:0] row,
    output logic [DIM_BITS-1:0] col,
    output logic                last
);

    logic [DIM_BITS-1:0] r_row;
    logic [DIM_BITS-1:0] r_col;
    logic                w_col_wrap;

    assign w_col_wrap = (r_col == n - DIM_BITS'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (advance) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + DIM_BITS'(1);
            end else begin
                r_col <= r_col + DIM_BITS'(1);
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = (r_row == m - DIM_BITS'(1)) && w_col_wrap;

endmodule
`default_nettype wire

// File: rtl/matrix_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : matrix_stream_loader
// Purpose  : Accepts a valid/ready byte stream made of one dimension header
//            (m in [6:4], n in [2:0]) followed by m*n row-major elements, and
//            packs them into a flat ROW_STRIDE x ROW_STRIDE matrix bus with
//            element (r,c) at bits [(r*ROW_STRIDE+c)*ELEM_W +: ELEM_W].
// Ports    : clk, reset   - clock, synchronous active-high reset
//            start        - begin a new load (clears matrix/count/error)
//            s_data/s_valid/s_ready - input stream handshake
//            mat_m, mat_n - loaded dimensions
//            matrix_out   - packed matrix, zero outside m x n
//            busy         - in HEADER or LOAD
//            done         - one-cycle pulse after the last element
//            error        - bad header (or idle timeout), held until start
//            elem_count   - elements accepted in the current load
// Options  : LOADER_TIMEOUT_EN - when defined, TIMEOUT_CYCLES idle cycles in
//            HEADER/LOAD without a transfer force the ERROR state.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int MAX_DIM        = PKG_MAX_DIM,
    parameter int ROW_STRIDE     = IN_STRIDE,
    parameter int ELEM_W         = PKG_ELEM_W,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [ELEM_W-1:0]                      s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic [2:0]                             mat_m,
    output logic [2:0]                             mat_n,
    output logic [ROW_STRIDE*ROW_STRIDE*ELEM_W-1:0] matrix_out,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic [4:0]                             elem_count
);

    localparam int c_num_elem = ROW_STRIDE * ROW_STRIDE;
    localparam int c_idx_w    = $clog2(c_num_elem);
    localparam logic [DIM_W-1:0] c_max_dim = DIM_W'(MAX_DIM);

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic [ROW_STRIDE*ROW_STRIDE*ELEM_W-1:0] r_matrix;
    logic [DIM_W-1:0]   r_mat_m;
    logic [DIM_W-1:0]   r_mat_n;
    logic [4:0]         r_elem_count;

    logic [DIM_W-1:0]   w_hdr_m;
    logic [DIM_W-1:0]   w_hdr_n;
    logic               w_hdr_ok;
    logic               w_busy;
    logic               w_xfer;
    logic               w_hdr_acc;
    logic               w_elem_acc;
    logic [DIM_W-1:0]   w_row;
    logic [DIM_W-1:0]   w_col;
    logic               w_last;
    logic [c_idx_w-1:0] w_idx;
    logic               w_timeout;

    // ------------------------------------------------------------------
    // Handshake decode. start wins over a transfer in the same cycle, so
    // a byte presented alongside start is dropped.
    // ------------------------------------------------------------------
    assign w_busy     = (r_state == ST_HEADER) || (r_state == ST_LOAD);
    assign w_xfer     = s_valid && w_busy && !start;
    assign w_hdr_m    = s_data[HDR_M_LSB +: DIM_W];
    assign w_hdr_n    = s_data[HDR_N_LSB +: DIM_W];
    assign w_hdr_ok   = (w_hdr_m != '0) && (w_hdr_m <= c_max_dim) &&
                        (w_hdr_n != '0) && (w_hdr_n <= c_max_dim);
    assign w_hdr_acc  = w_xfer && (r_state == ST_HEADER) && w_hdr_ok;
    assign w_elem_acc = w_xfer && (r_state == ST_LOAD);

    matrix_index_counter #(
        .DIM_BITS (DIM_W)
    ) u_index (
        .clk     (clk),
        .reset   (reset),
        .clear   (start || w_hdr_acc),
        .advance (w_elem_acc),
        .m       (r_mat_m),
        .n       (r_mat_n),
        .row     (w_row),
        .col     (w_col),
        .last    (w_last)
    );

    assign w_idx = c_idx_w'(w_row) * c_idx_w'(ROW_STRIDE) + c_idx_w'(w_col);

`ifdef LOADER_TIMEOUT_EN
    // Idle-gap counter: number of consecutive HEADER/LOAD cycles without a
    // transfer. The cycle that would make it reach TIMEOUT_CYCLES exits.
    localparam int c_gap_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_gap_w-1:0] r_gap;

    always_ff @(posedge clk) begin
        if (reset || start || w_xfer || !w_busy) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + c_gap_w'(1);
        end
    end

    assign w_timeout = w_busy && !w_xfer && !start &&
                       (r_gap == c_gap_w'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = ST_HEADER;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_next = ST_IDLE;
                ST_HEADER: begin
                    if (w_timeout) begin
                        w_state_next = ST_ERROR;
                    end else if (w_xfer) begin
                        w_state_next = w_hdr_ok ? ST_LOAD : ST_ERROR;
                    end
                end
                ST_LOAD: begin
                    if (w_timeout) begin
                        w_state_next = ST_ERROR;
                    end else if (w_elem_acc && w_last) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE:   w_state_next = ST_IDLE;
                ST_ERROR:  w_state_next = ST_ERROR;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: dimensions, packed matrix and element count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_matrix     <= '0;
            r_mat_m      <= '0;
            r_mat_n      <= '0;
            r_elem_count <= '0;
        end else begin
            if (w_hdr_acc) begin
                r_mat_m <= w_hdr_m;
                r_mat_n <= w_hdr_n;
            end
            if (w_elem_acc) begin
                for (int e = 0; e < c_num_elem; e++) begin
                    if (w_idx == c_idx_w'(e)) begin
                        r_matrix[e*ELEM_W +: ELEM_W] <= s_data;
                    end
                end
                r_elem_count <= r_elem_count + 5'd1;
            end
        end
    end

    assign s_ready    = w_busy;
    assign busy       = w_busy;
    assign done       = (r_state == ST_DONE);
    assign error      = (r_state == ST_ERROR);
    assign mat_m      = r_mat_m;
    assign mat_n      = r_mat_n;
    assign matrix_out = r_matrix;
    assign elem_count = r_elem_count;

endmodule
`default_nettype wire
